// File: rtl/rot_ctrl_if.sv
// DMA byte read/write handshake between the rotation sequencer (master) and the DMA engine (slave).
interface rot_ctrl_if #(
  parameter int AW = 32
);
  logic          O_ROTCTRL_RD_REQ;
  logic [AW-1:0] O_ROTCTRL_RD_ADDR;
  logic          I_ROTCTRL_RD_ACK;
  logic [7:0]    I_ROTCTRL_RD_DATA;
  logic          O_ROTCTRL_WR_REQ;
  logic [AW-1:0] O_ROTCTRL_WR_ADDR;
  logic [7:0]    O_ROTCTRL_WR_DATA;
  logic          I_ROTCTRL_WR_ACK;

  modport master (
    output O_ROTCTRL_RD_REQ, O_ROTCTRL_RD_ADDR, O_ROTCTRL_WR_REQ,
    output O_ROTCTRL_WR_ADDR, O_ROTCTRL_WR_DATA,
    input  I_ROTCTRL_RD_ACK, I_ROTCTRL_RD_DATA, I_ROTCTRL_WR_ACK
  );

  modport slave (
    input  O_ROTCTRL_RD_REQ, O_ROTCTRL_RD_ADDR, O_ROTCTRL_WR_REQ,
    input  O_ROTCTRL_WR_ADDR, O_ROTCTRL_WR_DATA,
    output I_ROTCTRL_RD_ACK, I_ROTCTRL_RD_DATA, I_ROTCTRL_WR_ACK
  );
endinterface

// File: rtl/rot_ctrl.sv
// Rotation sequencer: walks the source image row-major, one DMA read + rotated write per pixel.
// Optional busy-cycle counter enabled by ROT_CTRL_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a rising edge on start
// LOAD  | latch configuration, report rotated dimensions
// READ  | read request for pixel (x,y) outstanding
// WRITE | write request for captured pixel outstanding
// DONE  | one-cycle completion pulse
module rot_ctrl #(
  parameter int AW    = 32,
  parameter int DIM_W = 16
) (
  input  logic             I_ROTCTRL_PCLK,
  input  logic             I_ROTCTRL_PRESET,
  input  logic [AW-1:0]    I_ROTCTRL_DMA_SRC_IMG,
  input  logic [AW-1:0]    I_ROTCTRL_DMA_DST_IMG,
  input  logic [DIM_W-1:0] I_ROTCTRL_ROT_IMG_H,
  input  logic [DIM_W-1:0] I_ROTCTRL_ROT_IMG_W,
  input  logic [1:0]       I_ROTCTRL_ROT_IMG_MODE,
  input  logic             I_ROTCTRL_ROT_IMG_DIR,
  input  logic             I_ROTCTRL_CTRL_START,
  input  logic             I_ROTCTRL_CTRL_RESET,
  rot_ctrl_if.master       dma,
  output logic [DIM_W-1:0] O_ROTCTRL_ROT_IMG_NEW_H,
  output logic [DIM_W-1:0] O_ROTCTRL_ROT_IMG_NEW_W,
  output logic             O_ROTCTRL_BUSY,
  output logic             O_ROTCTRL_DONE,
  output logic [31:0]      O_ROTCTRL_CYCLE_CNT
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [DIM_W-1:0] D_ONE = DIM_W'(1);
  localparam logic [AW-1:0]    A_ONE = AW'(1);

  logic [2:0]       state_q, state_d;
  logic             start_q;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [DIM_W-1:0] h_q, h_d, w_q, w_d, x_q, x_d, y_q, y_d;
  logic [1:0]       r_q, r_d;
  logic [AW-1:0]    lin_q, lin_d, xh_q, xh_d, hw_q, hw_d;
  logic [7:0]       data_q, data_d;
  logic [DIM_W-1:0] new_h_q, new_h_d, new_w_q, new_w_d;
  logic             rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             start_ev;
  logic [1:0]       rot;
  logic [AW-1:0]    h_ext, y_ext, wr_off;

  assign start_ev = I_ROTCTRL_CTRL_START & ~start_q;
  assign rot      = I_ROTCTRL_ROT_IMG_DIR ? (2'd0 - I_ROTCTRL_ROT_IMG_MODE) : I_ROTCTRL_ROT_IMG_MODE;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    h_d     = h_q;
    w_d     = w_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    lin_d   = lin_q;
    xh_d    = xh_q;
    hw_d    = hw_q;
    data_d  = data_q;
    new_h_d = new_h_q;
    new_w_d = new_w_q;
    case (state_q)
      S_IDLE: if (start_ev) state_d = S_LOAD;
      S_LOAD: begin
        src_d   = I_ROTCTRL_DMA_SRC_IMG;
        dst_d   = I_ROTCTRL_DMA_DST_IMG;
        h_d     = I_ROTCTRL_ROT_IMG_H;
        w_d     = I_ROTCTRL_ROT_IMG_W;
        r_d     = rot;
        hw_d    = AW'(I_ROTCTRL_ROT_IMG_H) * AW'(I_ROTCTRL_ROT_IMG_W);
        new_h_d = rot[0] ? I_ROTCTRL_ROT_IMG_W : I_ROTCTRL_ROT_IMG_H;
        new_w_d = rot[0] ? I_ROTCTRL_ROT_IMG_H : I_ROTCTRL_ROT_IMG_W;
        x_d     = '0;
        y_d     = '0;
        lin_d   = '0;
        xh_d    = '0;
        state_d = (I_ROTCTRL_ROT_IMG_H == '0 || I_ROTCTRL_ROT_IMG_W == '0) ? S_DONE : S_READ;
      end
      S_READ: if (dma.I_ROTCTRL_RD_ACK) begin
        data_d  = dma.I_ROTCTRL_RD_DATA;
        state_d = S_WRITE;
      end
      S_WRITE: if (dma.I_ROTCTRL_WR_ACK) begin
        // lin tracks y*W+x and xh tracks x*H, so no multiplier sits in the pixel loop
        lin_d = lin_q + A_ONE;
        if (x_q == w_q - D_ONE) begin
          x_d  = '0;
          xh_d = '0;
          if (y_q == h_q - D_ONE) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + D_ONE;
            state_d = S_READ;
          end
        end else begin
          x_d     = x_q + D_ONE;
          xh_d    = xh_q + AW'(h_q);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (I_ROTCTRL_CTRL_RESET) begin
      state_d = S_IDLE;
      src_d   = '0;
      dst_d   = '0;
      h_d     = '0;
      w_d     = '0;
      r_d     = '0;
      x_d     = '0;
      y_d     = '0;
      lin_d   = '0;
      xh_d    = '0;
      hw_d    = '0;
      data_d  = '0;
    end
    rd_req_d = (state_d == S_READ);
    wr_req_d = (state_d == S_WRITE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge I_ROTCTRL_PCLK) begin
    if (I_ROTCTRL_PRESET) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      h_q      <= '0;
      w_q      <= '0;
      r_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      lin_q    <= '0;
      xh_q     <= '0;
      hw_q     <= '0;
      data_q   <= '0;
      new_h_q  <= '0;
      new_w_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= I_ROTCTRL_CTRL_START;
      src_q    <= src_d;
      dst_q    <= dst_d;
      h_q      <= h_d;
      w_q      <= w_d;
      r_q      <= r_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lin_q    <= lin_d;
      xh_q     <= xh_d;
      hw_q     <= hw_d;
      data_q   <= data_d;
      new_h_q  <= new_h_d;
      new_w_q  <= new_w_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Rotated offsets rewritten in terms of lin = y*W+x and xh = x*H
  always_comb begin
    h_ext = AW'(h_q);
    y_ext = AW'(y_q);
    case (r_q)
      2'd1:    wr_off = xh_q + h_ext - A_ONE - y_ext;
      2'd2:    wr_off = hw_q - A_ONE - lin_q;
      2'd3:    wr_off = hw_q - h_ext - xh_q + y_ext;
      default: wr_off = lin_q;
    endcase
  end

  assign dma.O_ROTCTRL_RD_REQ  = rd_req_q;
  assign dma.O_ROTCTRL_RD_ADDR = src_q + lin_q;
  assign dma.O_ROTCTRL_WR_REQ  = wr_req_q;
  assign dma.O_ROTCTRL_WR_ADDR = dst_q + wr_off;
  assign dma.O_ROTCTRL_WR_DATA = data_q;
  assign O_ROTCTRL_ROT_IMG_NEW_H = new_h_q;
  assign O_ROTCTRL_ROT_IMG_NEW_W = new_w_q;
  assign O_ROTCTRL_BUSY = busy_q;
  assign O_ROTCTRL_DONE = done_q;

`ifdef ROT_CTRL_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge I_ROTCTRL_PCLK) begin
    if (I_ROTCTRL_PRESET || I_ROTCTRL_CTRL_RESET) begin
      cnt_q <= '0;
    end else if (state_q == S_LOAD) begin
      cnt_q <= '0;
    end else if (busy_q && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
  assign O_ROTCTRL_CYCLE_CNT = cnt_q;
`else
  assign O_ROTCTRL_CYCLE_CNT = 32'd0;
`endif
endmodule

// File: tb/tb_rot_ctrl.sv
// Self-checking bench for rot_ctrl: DMA responder with random latencies and a geometric rotation model.
module tb_rot_ctrl;
  localparam int AW = 32;
  localparam int DIM_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, srst, dir;
  logic [31:0] src, dst;
  logic [15:0] h, w;
  logic [1:0]  mode;
  logic [15:0] new_h, new_w;
  logic        busy, done;
  logic [31:0] cyc;

  rot_ctrl_if #(.AW(AW)) dma ();

  rot_ctrl #(.AW(AW), .DIM_W(DIM_W)) dut (
    .I_ROTCTRL_PCLK(clk),
    .I_ROTCTRL_PRESET(rst),
    .I_ROTCTRL_DMA_SRC_IMG(src),
    .I_ROTCTRL_DMA_DST_IMG(dst),
    .I_ROTCTRL_ROT_IMG_H(h),
    .I_ROTCTRL_ROT_IMG_W(w),
    .I_ROTCTRL_ROT_IMG_MODE(mode),
    .I_ROTCTRL_ROT_IMG_DIR(dir),
    .I_ROTCTRL_CTRL_START(start),
    .I_ROTCTRL_CTRL_RESET(srst),
    .dma(dma),
    .O_ROTCTRL_ROT_IMG_NEW_H(new_h),
    .O_ROTCTRL_ROT_IMG_NEW_W(new_w),
    .O_ROTCTRL_BUSY(busy),
    .O_ROTCTRL_DONE(done),
    .O_ROTCTRL_CYCLE_CNT(cyc)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Destination pixel position in the rotated picture, linearised with the rotated width
  function automatic logic [31:0] model_wr(input logic [31:0] d, input int hh, input int ww,
                                           input int rr, input int y, input int x);
    int row, col, nw;
    case (rr)
      1:       begin row = x;          col = hh - 1 - y; nw = hh; end
      2:       begin row = hh - 1 - y; col = ww - 1 - x; nw = ww; end
      3:       begin row = ww - 1 - x; col = y;          nw = hh; end
      default: begin row = y;          col = x;          nw = ww; end
    endcase
    return d + 32'(row * nw + col);
  endfunction

  task automatic run_op(input logic [31:0] s, input logic [31:0] d, input int hh, input int ww,
                        input int md, input logic dr, input int maxd, input int stall_rd,
                        input bit toggle);
    logic [31:0] q_rd[$];
    logic [31:0] q_wr[$];
    logic [31:0] hold_addr;
    logic [7:0]  byte_q;
    int rr, pix, dones, busyc, rdw, wrw, tog;
    bit anyreq, fin, seen_done;
    rr = dr ? (4 - md) % 4 : md;
    for (int y = 0; y < hh; y++)
      for (int x = 0; x < ww; x++) begin
        q_rd.push_back(s + 32'(y * ww + x));
        q_wr.push_back(model_wr(d, hh, ww, rr, y, x));
      end
    pix = 0; dones = 0; busyc = 0; rdw = -1; wrw = -1; tog = 0;
    anyreq = 0; fin = 0; seen_done = 0; byte_q = 8'h00; hold_addr = '0;
    @(negedge clk);
    src = s; dst = d; h = 16'(hh); w = 16'(ww); mode = 2'(md); dir = dr; start = 1'b1;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      dma.I_ROTCTRL_RD_ACK = 1'b0;
      dma.I_ROTCTRL_WR_ACK = 1'b0;
      if (c == 1) begin
        src = $urandom; dst = $urandom; h = 16'($urandom); w = 16'($urandom);
        mode = 2'($urandom); dir = 1'($urandom);
      end
      if (toggle && pix == 1 && tog == 0) begin start = 1'b0; tog = 1; end
      else if (tog == 1) begin start = 1'b1; tog = 2; end
      if (seen_done) begin
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_width", 32'(done), 32'd0);
        fin = 1;
      end else begin
        if (busy) busyc++;
        if (done) begin dones++; seen_done = 1; end
        if (dma.O_ROTCTRL_RD_REQ && dma.O_ROTCTRL_WR_REQ) check("req_overlap", 32'd1, 32'd0);
        if (dma.O_ROTCTRL_RD_REQ || dma.O_ROTCTRL_WR_REQ) anyreq = 1;
        if (dma.O_ROTCTRL_RD_REQ) begin
          if (rdw < 0) begin
            rdw = (pix == 0 && stall_rd > 0) ? stall_rd : $urandom_range(0, maxd);
            hold_addr = dma.O_ROTCTRL_RD_ADDR;
          end else begin
            check("rd_addr_stable", dma.O_ROTCTRL_RD_ADDR, hold_addr);
          end
          if (rdw == 0) begin
            if (pix < q_rd.size()) check("rd_addr", dma.O_ROTCTRL_RD_ADDR, q_rd[pix]);
            else check("extra_read", 32'(pix), 32'(q_rd.size()));
            byte_q = 8'($urandom);
            dma.I_ROTCTRL_RD_DATA = byte_q;
            dma.I_ROTCTRL_RD_ACK = 1'b1;
            rdw = -1;
          end else begin
            rdw--;
            dma.I_ROTCTRL_WR_ACK = 1'($urandom);
            dma.I_ROTCTRL_RD_DATA = 8'($urandom);
          end
        end else if (dma.O_ROTCTRL_WR_REQ) begin
          if (wrw < 0) wrw = $urandom_range(0, maxd);
          if (wrw == 0) begin
            if (pix < q_wr.size()) check("wr_addr", dma.O_ROTCTRL_WR_ADDR, q_wr[pix]);
            else check("extra_write", 32'(pix), 32'(q_wr.size()));
            check("wr_data", 32'(dma.O_ROTCTRL_WR_DATA), 32'(byte_q));
            dma.I_ROTCTRL_WR_ACK = 1'b1;
            wrw = -1;
            pix++;
          end else begin
            wrw--;
            dma.I_ROTCTRL_RD_ACK = 1'($urandom);
          end
        end
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    check("pixel_count", 32'(pix), 32'(hh * ww));
    check("done_pulses", 32'(dones), 32'd1);
    check("new_h", 32'(new_h), 32'((rr % 2) ? ww : hh));
    check("new_w", 32'(new_w), 32'((rr % 2) ? hh : ww));
    if (hh * ww == 0) check("zero_dim_no_req", 32'(anyreq), 32'd0);
`ifdef ROT_CTRL_PERF_CNT_EN
    check("cycle_cnt", cyc, 32'(busyc - 1));
`else
    check("cycle_cnt", cyc, 32'd0);
`endif
    repeat (3) @(negedge clk);
    check("no_retrigger", 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; start = 1'b0; srst = 1'b0; dir = 1'b0; mode = 2'd0;
    src = '0; dst = '0; h = '0; w = '0;
    dma.I_ROTCTRL_RD_ACK = 1'b0; dma.I_ROTCTRL_WR_ACK = 1'b0; dma.I_ROTCTRL_RD_DATA = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_req", 32'(dma.O_ROTCTRL_RD_REQ), 32'd0);
    check("rst_wr_req", 32'(dma.O_ROTCTRL_WR_REQ), 32'd0);
    check("rst_rd_addr", dma.O_ROTCTRL_RD_ADDR, 32'd0);
    check("rst_wr_addr", dma.O_ROTCTRL_WR_ADDR, 32'd0);
    check("rst_new_h", 32'(new_h), 32'd0);
    check("rst_new_w", 32'(new_w), 32'd0);
    check("rst_cycle_cnt", cyc, 32'd0);
    rst = 1'b0;

    run_op(32'h1000, 32'h2000, 2, 3, 1, 1'b0, 0, 0, 0);
    run_op(32'h0, 32'h0, 2, 2, 2, 1'b0, 2, 0, 0);
    run_op(32'h0, 32'h0, 2, 2, 1, 1'b1, 2, 0, 0);
    run_op(32'h0, 32'h0, 2, 2, 3, 1'b0, 1, 0, 0);
    run_op(32'h10, 32'h20, 0, 5, 1, 1'b0, 0, 0, 0);
    run_op(32'h10, 32'h20, 4, 0, 2, 1'b1, 0, 0, 0);
    run_op(32'h4000, 32'h8000, 3, 4, 3, 1'b1, 2, 10, 1);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFF0, 3, 5, 2, 1'b0, 1, 0, 0);

    // soft reset in the middle of a write
    @(negedge clk);
    src = 32'h100; dst = 32'h200; h = 16'd3; w = 16'd4; mode = 2'd1; dir = 1'b0; start = 1'b1;
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      dma.I_ROTCTRL_RD_ACK = dma.O_ROTCTRL_RD_REQ;
      if (dma.O_ROTCTRL_WR_REQ) reached = 1;
    end
    if (!reached) check("srst_timeout", 32'd0, 32'd1);
    dma.I_ROTCTRL_RD_ACK = 1'b0;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("srst_busy", 32'(busy), 32'd0);
    check("srst_wr_req", 32'(dma.O_ROTCTRL_WR_REQ), 32'd0);
    check("srst_rd_req", 32'(dma.O_ROTCTRL_RD_REQ), 32'd0);
    check("srst_new_h", 32'(new_h), 32'd4);
    check("srst_new_w", 32'(new_w), 32'd3);
    check("srst_cycle_cnt", cyc, 32'd0);
    repeat (2) @(negedge clk);
    check("srst_stays_idle", 32'(busy), 32'd0);
    start = 1'b0;
    run_op(32'h300, 32'h500, 3, 4, 1, 1'b0, 1, 0, 0);

    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, $urandom_range(1, 5), $urandom_range(1, 5),
             $urandom_range(0, 3), 1'($urandom), 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rot_ctrl.md
Name: rot_ctrl

Overview:
Rotation core sequencer directly downstream of the APB register interface. Consumes the latched image configuration (source/destination base, H, W, mode, direction, start, soft reset). Walks the source image pixel by pixel in row-major order, issuing one byte read and one byte write per pixel to the DMA port at the rotated destination address. Returns the rotated dimensions to the register interface, and reports busy/done.

Parameters:
AW, 32, address width of DMA source/destination addresses
DIM_W, 16, width of image height/width fields

Ports:
I_ROTCTRL_PCLK  input  1  clock
I_ROTCTRL_PRESET  input  1  synchronous active-high reset
I_ROTCTRL_DMA_SRC_IMG  input  AW  source image byte base address
I_ROTCTRL_DMA_DST_IMG  input  AW  destination image byte base address
I_ROTCTRL_ROT_IMG_H  input  DIM_W  source height H (rows)
I_ROTCTRL_ROT_IMG_W  input  DIM_W  source width W (pixels per row)
I_ROTCTRL_ROT_IMG_MODE  input  2  0=0deg, 1=90deg, 2=180deg, 3=270deg
I_ROTCTRL_ROT_IMG_DIR  input  1  0=clockwise, 1=counter-clockwise
I_ROTCTRL_CTRL_START  input  1  start level from register file
I_ROTCTRL_CTRL_RESET  input  1  soft reset level from register file
I_ROTCTRL_RD_ACK  input  1  DMA read complete; I_ROTCTRL_RD_DATA valid this cycle
I_ROTCTRL_RD_DATA  input  8  read pixel
I_ROTCTRL_WR_ACK  input  1  DMA write accepted
O_ROTCTRL_RD_REQ  output  1  read request
O_ROTCTRL_RD_ADDR  output  AW  read byte address
O_ROTCTRL_WR_REQ  output  1  write request
O_ROTCTRL_WR_ADDR  output  AW  write byte address
O_ROTCTRL_WR_DATA  output  8  write pixel
O_ROTCTRL_ROT_IMG_NEW_H  output  DIM_W  rotated height, to register interface
O_ROTCTRL_ROT_IMG_NEW_W  output  DIM_W  rotated width, to register interface
O_ROTCTRL_BUSY  output  1  operation in progress
O_ROTCTRL_DONE  output  1  one-cycle completion pulse
O_ROTCTRL_CYCLE_CNT  output  32  busy-cycle counter (see Optional Feature)

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs reset to 0. State resets to IDLE.
- Soft reset: I_ROTCTRL_CTRL_RESET=1 behaves like reset, except NEW_H/NEW_W keep their values. It aborts any transfer immediately. It wins over a simultaneous start.
- Start detect: START is registered. A start event is start=1 while the registered copy is 0 (rising edge). Start events outside IDLE are ignored.
- FSM states: IDLE, LOAD, READ, WRITE, DONE.
- IDLE: on start event go to LOAD next cycle.
- LOAD (1 cycle): latch all config inputs. Changes to inputs after this point have no effect until the next start.
  - Effective rotation r = DIR ? (4-MODE) mod 4 : MODE.
  - NEW_W/NEW_H: for r even, NEW_W=W and NEW_H=H; for r odd, NEW_W=H and NEW_H=W. Both are updated in LOAD.
  - Clear x,y to 0.
  - If H==0 or W==0, go to DONE. Otherwise go to READ.
- READ: RD_REQ=1, RD_ADDR = SRC + y*W + x. Hold both stable until RD_ACK. On RD_ACK, capture RD_DATA and go to WRITE.
- WRITE: WR_REQ=1, WR_DATA = captured byte. Hold stable until WR_ACK. WR_ADDR by r:
  - r=0: DST + y*W + x
  - r=1: DST + x*H + (H-1-y)
  - r=2: DST + (H-1-y)*W + (W-1-x)
  - r=3: DST + (W-1-x)*H + y
- On WR_ACK:
  - If x==W-1 and y==H-1, go to DONE.
  - Else if x==W-1, set x=0, y=y+1, go to READ.
  - Else x=x+1, go to READ.
- DONE: DONE=1 for exactly one cycle, then IDLE.
- BUSY=1 in LOAD, READ, WRITE and DONE.
- REQ outputs are registered. Earliest first RD_REQ is 3 cycles after START rises: register, LOAD, READ.
- One outstanding request at a time. RD_REQ and WR_REQ are never high together.
- An ACK received in a state not expecting it is ignored.
- All address arithmetic is AW bits, modulo 2^AW. Products may be computed incrementally; results must equal the formulas above.
- START held high across completion does not retrigger. A new start requires START to go low then high.

Optional Feature:
ROT_CTRL_PERF_CNT_EN
- Defined: O_ROTCTRL_CYCLE_CNT clears in LOAD and increments every cycle BUSY=1, saturating at 0xFFFFFFFF. It holds its value in IDLE. Reset and soft reset clear it.
- Undefined: O_ROTCTRL_CYCLE_CNT is constant 0 and no counter logic is built.

Test Plan:
- W=3, H=2, MODE=1, DIR=0, SRC=0x1000, DST=0x2000, ACKs one cycle after REQ.
  - Read addresses must be 0x1000..0x1005 in order.
  - Write addresses must be 0x2001, 0x2003, 0x2005, 0x2000, 0x2002, 0x2004.
  - NEW_W=2, NEW_H=3; one DONE pulse.
- W=2, H=2, MODE=2, DIR=0, DST=0x0 -> write addresses 0x3, 0x2, 0x1, 0x0.
- W=2, H=2, MODE=1, DIR=1: must match the MODE=3, DIR=0 run, giving writes 0x2, 0x0, 0x3, 0x1. Data bytes must pass through unchanged.
- H=0, W=5, start -> no REQ asserted; DONE pulses 2 cycles after LOAD entry; NEW_H=5, NEW_W=0 with MODE=1.
- RD_ACK stalled 10 cycles -> RD_ADDR stable throughout. Second START edge while BUSY -> ignored, pixel count unchanged.
- Soft reset asserted mid-WRITE -> next cycle IDLE, BUSY=0, WR_REQ=0, NEW_H/NEW_W retained. A fresh start afterwards completes normally.
